// File: rtl/square_gen_bcd_ctrl.sv
// square_gen_bcd_ctrl: BCD-entered frequency setting, sequential BCD->binary and
// restoring division to a half-period, and a glitch-free square output stage.
module square_gen_bcd_ctrl #(
    parameter int CLK_HZ = 50_000_000,
    parameter int DIGITS = 6,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_p,
    input  logic                  dec_p,
    input  logic                  cur_up_p,
    input  logic                  cur_dn_p,
    input  logic                  out_en,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [3:0]            cursor,
    output logic [CNT_W-1:0]      freq_hz,
    output logic                  busy,
    output logic                  square,
    output logic                  rise_p
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(CNT_W + DIGITS) + 1;
    localparam logic [BW-1:0] ONE = BW'(1);
    localparam logic [3:0] LAST_DIG = 4'(DIGITS - 1);
    localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(CLK_HZ / 2);
    localparam logic [CNT_W-1:0] INIT_HALF = (DIVIDEND == '0) ? CNT_W'(1) : DIVIDEND;

    typedef enum logic [1:0] {IDLE, B2B, DIV, LOAD} state_t;

    state_t             r_state, w_nstate;
    logic [BW-1:0]      r_bcd, w_inc_bcd, w_dec_bcd, w_nxt_bcd;
    logic [3:0]         r_cursor, w_nxt_cur, w_idx, w_digit;
    logic [CW-1:0]      r_cnt;
    logic [CNT_W-1:0]   r_acc, r_freq, r_rem, r_quo, r_pending, r_active, r_phase, w_acc10;
    logic [CNT_W:0]     w_sh, w_diff;
    logic [4:0]         w_sum, w_sub;
    logic               w_carry, w_borrow, w_start, w_ge, w_busy, r_square, r_rise;

    // Ripple the +/-10^cursor through all digits; carry/borrow out flags range overflow.
    always_comb begin
        w_inc_bcd = r_bcd;
        w_dec_bcd = r_bcd;
        w_carry   = 1'b0;
        w_borrow  = 1'b0;
        w_sum     = '0;
        w_sub     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_sum = {1'b0, r_bcd[4*i +: 4]} + {4'b0, (4'(i) == r_cursor)} + {4'b0, w_carry};
            w_carry = w_sum > 5'd9;
            w_inc_bcd[4*i +: 4] = w_carry ? 4'(w_sum - 5'd10) : w_sum[3:0];
            w_sub = {4'b0, (4'(i) == r_cursor)} + {4'b0, w_borrow};
            w_borrow = {1'b0, r_bcd[4*i +: 4]} < w_sub;
            w_dec_bcd[4*i +: 4] = 4'({1'b0, r_bcd[4*i +: 4]} + (w_borrow ? 5'd10 : 5'd0) - w_sub);
        end
    end

    assign w_nxt_bcd = (inc_p && !dec_p) ? (w_carry ? r_bcd : w_inc_bcd)
                     : (dec_p && !inc_p) ? ((w_borrow || w_dec_bcd == '0) ? ONE : w_dec_bcd)
                     : r_bcd;
    assign w_start   = w_nxt_bcd != r_bcd;
    assign w_nxt_cur = (cur_up_p && !cur_dn_p) ? ((r_cursor == LAST_DIG) ? 4'd0 : r_cursor + 4'd1)
                     : (cur_dn_p && !cur_up_p) ? ((r_cursor == 4'd0) ? LAST_DIG : r_cursor - 4'd1)
                     : r_cursor;

    assign w_idx   = LAST_DIG - r_cnt[3:0];
    assign w_digit = 4'(r_bcd >> {w_idx, 2'b00});
    assign w_acc10 = (r_acc << 3) + (r_acc << 1) + CNT_W'(w_digit);
    assign w_sh    = {r_rem, r_quo[CNT_W-1]};
    assign w_ge    = w_sh >= {1'b0, r_freq};
    assign w_diff  = w_sh - {1'b0, r_freq};

    always_comb begin
        w_nstate = r_state;
        w_busy   = r_state != IDLE;
        if (w_start)
            w_nstate = B2B;
        else if (r_state == B2B && r_cnt == CW'(DIGITS - 1))
            w_nstate = DIV;
        else if (r_state == DIV && r_cnt == CW'(CNT_W - 1))
            w_nstate = LOAD;
        else if (r_state == LOAD)
            w_nstate = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_nstate;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcd     <= ONE;
            r_cursor  <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_freq    <= CNT_W'(1);
            r_rem     <= '0;
            r_quo     <= '0;
            r_pending <= INIT_HALF;
        end else begin
            r_bcd    <= w_nxt_bcd;
            r_cursor <= w_nxt_cur;
            r_cnt    <= (w_start || w_nstate != r_state || r_state == IDLE) ? '0 : r_cnt + CW'(1);
            if (w_start) begin
                r_acc <= '0;
            end else if (r_state == B2B) begin
                r_acc <= w_acc10;
                r_rem <= '0;
                r_quo <= DIVIDEND;
                if (r_cnt == CW'(DIGITS - 1))
                    r_freq <= w_acc10;
            end else if (r_state == DIV) begin
                r_rem <= w_ge ? w_diff[CNT_W-1:0] : w_sh[CNT_W-1:0];
                r_quo <= {r_quo[CNT_W-2:0], w_ge};
            end else if (r_state == LOAD) begin
                r_pending <= (r_quo == '0) ? CNT_W'(1) : r_quo;
            end
        end
    end

    // The new half-period is only adopted at a toggle so every phase runs full length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase  <= '0;
            r_square <= 1'b0;
            r_rise   <= 1'b0;
            r_active <= INIT_HALF;
        end else if (!out_en) begin
            r_phase  <= '0;
            r_square <= 1'b0;
            r_rise   <= 1'b0;
        end else if (r_phase == r_active - CNT_W'(1)) begin
            r_phase  <= '0;
            r_square <= ~r_square;
            r_rise   <= ~r_square;
            r_active <= r_pending;
        end else begin
            r_phase  <= r_phase + CNT_W'(1);
            r_rise   <= 1'b0;
        end
    end

    assign bcd     = r_bcd;
    assign cursor  = r_cursor;
    assign freq_hz = r_freq;
    assign busy    = w_busy;
    assign square  = r_square;
    assign rise_p  = r_rise;
endmodule
